// File: rtl/sprite_pkg.sv
// Shared field layouts and constants for the sprite address path.
package sprite_pkg;

    // Pattern descriptor: ROM base pixel index, source size, on-screen box size.
    typedef struct packed {
        logic [15:0] base;
        logic [15:0] src_w;
        logic [15:0] src_h;
        logic [15:0] scr_w;
        logic [15:0] scr_h;
    } pattern_info_t;

    // Per-sprite placement word; low 10 bits carry no meaning here.
    typedef struct packed {
        logic       visible;
        logic       flip;
        logic [9:0] x;
        logic [9:0] y;
        logic [9:0] reserved;
    } sprite_info_t;

    localparam logic [15:0] INVALID_ADDR = 16'hFFFF;

endpackage

// File: rtl/sprite_hit.sv
// Combinational coverage test for one sprite at the current beam position.
// Produces the hit flag and the in-box offsets dx/dy (zero when outside).
module sprite_hit
    import sprite_pkg::*;
(
    input  pattern_info_t pattern,
    input  sprite_info_t  sprite,
    input  logic [9:0]    hcount,
    input  logic [9:0]    vcount,
    output logic          hit,
    output logic [15:0]   dx,
    output logic [15:0]   dy
);

    logic [16:0] x_end_s;
    logic [16:0] y_end_s;
    logic        in_box_s;
    logic [9:0]  dx_raw_s;
    logic [9:0]  dy_raw_s;
    logic        unused_s;

    // Fields that play no part in the coverage decision.
    assign unused_s = ^{pattern.base, sprite.flip, sprite.reserved};

    // Box ends are 17 bits wide so a box running past the screen edge never wraps.
    always_comb begin
        x_end_s = {7'd0, sprite.x} + {1'b0, pattern.scr_w};
        y_end_s = {7'd0, sprite.y} + {1'b0, pattern.scr_h};
    end

    // Box test, offsets, then the source-size bound; pixels past the source are transparent.
    always_comb begin
        in_box_s = 1'b0;
        dx_raw_s = 10'd0;
        dy_raw_s = 10'd0;
        dx       = 16'd0;
        dy       = 16'd0;
        hit      = 1'b0;
        if ((hcount >= sprite.x) && ({7'd0, hcount} < x_end_s) &&
            (vcount >= sprite.y) && ({7'd0, vcount} < y_end_s)) begin
            in_box_s = 1'b1;
        end else begin
            in_box_s = 1'b0;
        end
        if (in_box_s) begin
            dx_raw_s = hcount - sprite.x;
            dy_raw_s = vcount - sprite.y;
            dx       = {6'd0, dx_raw_s};
            dy       = {6'd0, dy_raw_s};
            hit      = sprite.visible && (dx < pattern.src_w) && (dy < pattern.src_h);
        end else begin
            hit      = 1'b0;
        end
    end

endmodule

// File: rtl/sprite_addr_calc.sv
// Per-pixel sprite ROM address generator with one register stage.
// Optional horizontal mirroring is built only when ADDR_CAL_FLIP_EN is defined.
module sprite_addr_calc
    import sprite_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [79:0] pattern_info,
    input  logic [31:0] sprite_info,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    output logic [15:0] addr_output,
    output logic        valid
);

    pattern_info_t pattern_s;
    sprite_info_t  sprite_s;
    logic          hit_s;
    logic [15:0]   dx_s;
    logic [15:0]   dy_s;
    logic [15:0]   col_s;
    logic [15:0]   addr_s;
    logic [15:0]   addr_next_s;
    logic          valid_next_s;
    logic [15:0]   addr_r;
    logic          valid_r;

    assign pattern_s = pattern_info_t'(pattern_info);
    assign sprite_s  = sprite_info_t'(sprite_info);

    sprite_hit u_hit (
        .pattern (pattern_s),
        .sprite  (sprite_s),
        .hcount  (hcount),
        .vcount  (vcount),
        .hit     (hit_s),
        .dx      (dx_s),
        .dy      (dy_s)
    );

`ifdef ADDR_CAL_FLIP_EN
    // Mirrored column counts back from the right edge of the source image.
    always_comb begin
        col_s = dx_s;
        if (sprite_s.flip) begin
            col_s = pattern_s.src_w - 16'd1 - dx_s;
        end else begin
            col_s = dx_s;
        end
    end
`else
    // Without mirroring the column is simply the in-box offset.
    always_comb begin
        col_s = dx_s;
    end
`endif

    // Row-major pixel index; wraps modulo 2^16, range checking is downstream.
    always_comb begin
        addr_s = pattern_s.base + (dy_s * pattern_s.src_w) + col_s;
    end

    // Select the value to register: the address on a hit, the invalid marker otherwise.
    always_comb begin
        valid_next_s = 1'b0;
        addr_next_s  = INVALID_ADDR;
        if (hit_s) begin
            valid_next_s = 1'b1;
            addr_next_s  = addr_s;
        end else begin
            valid_next_s = 1'b0;
            addr_next_s  = INVALID_ADDR;
        end
    end

    // Output register; reset forces the invalid state immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_r <= 1'b0;
            addr_r  <= INVALID_ADDR;
        end else begin
            valid_r <= valid_next_s;
            addr_r  <= addr_next_s;
        end
    end

    assign valid       = valid_r;
    assign addr_output = addr_r;

endmodule

// File: tb/tb_sprite_addr_calc.sv
// Self-checking bench for sprite_addr_calc: directed cases plus randomized
// stimulus against an arithmetic reference model.
module tb_sprite_addr_calc;

    logic        clk;
    logic        reset;
    logic [79:0] pattern_info;
    logic [31:0] sprite_info;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic [15:0] addr_output;
    logic        valid;

    int total;
    int bad;

    sprite_addr_calc dut (
        .clk          (clk),
        .reset        (reset),
        .pattern_info (pattern_info),
        .sprite_info  (sprite_info),
        .hcount       (hcount),
        .vcount       (vcount),
        .addr_output  (addr_output),
        .valid        (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [79:0] mk_pat(input int b, input int sw, input int sh,
                                           input int cw, input int ch);
        logic [79:0] p;
        p = {b[15:0], sw[15:0], sh[15:0], cw[15:0], ch[15:0]};
        return p;
    endfunction

    function automatic logic [31:0] mk_spr(input bit vis, input bit flp,
                                           input int x, input int y);
        logic [31:0] s;
        s = {vis, flp, x[9:0], y[9:0], 10'd0};
        return s;
    endfunction

    // Reference model written straight from the coverage and address rules.
    function automatic void model(input logic [79:0] p, input logic [31:0] s,
                                  input logic [9:0] h, input logic [9:0] v,
                                  output logic ev, output logic [15:0] ea);
        longint base, srcw, srch, scrw, scrh, x, y, hh, vv, dx, dy, col, a;
        bit vis, flp;
        base = p[79:64]; srcw = p[63:48]; srch = p[47:32];
        scrw = p[31:16]; scrh = p[15:0];
        vis = s[31]; flp = s[30]; x = s[29:20]; y = s[19:10];
        hh = h; vv = v;
        dx = hh - x; dy = vv - y;
        if (vis && hh >= x && hh < x + scrw && vv >= y && vv < y + scrh &&
            dx < srcw && dy < srch) begin
`ifdef ADDR_CAL_FLIP_EN
            col = flp ? (srcw - 1 - dx) : dx;
`else
            col = dx;
`endif
            a  = (base + dy * srcw + col) % 65536;
            ev = 1'b1;
            ea = a[15:0];
        end else begin
            ev = 1'b0;
            ea = 16'hFFFF;
        end
    endfunction

    task automatic chk(input string tag, input logic ev, input logic [15:0] ea);
        total++;
        assert (valid === ev) else begin
            bad++;
            $error("FAIL %s valid: got %0b expected %0b", tag, valid, ev);
        end
        total++;
        assert (addr_output === ea) else begin
            bad++;
            $error("FAIL %s addr: got %0d expected %0d", tag, addr_output, ea);
        end
    endtask

    // Apply inputs away from the edge, then sample 1 time unit after the capturing edge.
    task automatic step(input logic [79:0] p, input logic [31:0] s,
                        input int h, input int v);
        @(negedge clk);
        pattern_info = p;
        sprite_info  = s;
        hcount       = h[9:0];
        vcount       = v[9:0];
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [79:0] p;
        logic [31:0] s;
        logic [9:0]  h, v;
        logic        ev;
        logic [15:0] ea;
        int          x, y;

        total = 0;
        bad   = 0;
        reset = 1'b0;
        pattern_info = '0;
        sprite_info  = '0;
        hcount = 10'd0;
        vcount = 10'd0;
        #12;
        chk("reset_state", 1'b0, 16'hFFFF);
        @(negedge clk);
        reset = 1'b1;

        // Basic placement
        p = mk_pat(256, 16, 16, 16, 16);
        s = mk_spr(1'b1, 1'b0, 100, 50);
        step(p, s, 100, 50); chk("corner_tl", 1'b1, 16'd256);
        step(p, s, 115, 65); chk("corner_br", 1'b1, 16'd511);
        step(p, s, 116, 50); chk("right_out", 1'b0, 16'hFFFF);
        step(p, s, 99, 50);  chk("left_out", 1'b0, 16'hFFFF);
        step(p, mk_spr(1'b0, 1'b0, 100, 50), 100, 50); chk("invisible", 1'b0, 16'hFFFF);

        // Base offset and flip
        p = mk_pat(1792, 16, 32, 16, 32);
        step(p, mk_spr(1'b1, 1'b0, 0, 0), 3, 20); chk("base_noflip", 1'b1, 16'd2115);
        step(p, mk_spr(1'b1, 1'b1, 0, 0), 3, 20);
`ifdef ADDR_CAL_FLIP_EN
        chk("base_flip", 1'b1, 16'd2124);
`else
        chk("base_flip", 1'b1, 16'd2115);
`endif

        // Screen box larger than source: transparent margin
        p = mk_pat(0, 16, 16, 32, 32);
        s = mk_spr(1'b1, 1'b0, 10, 10);
        step(p, s, 30, 12); chk("beyond_src", 1'b0, 16'hFFFF);
        step(p, s, 25, 12); chk("inside_src", 1'b1, 16'd47);

        // Box running past the right screen edge
        p = mk_pat(0, 16, 16, 16, 16);
        s = mk_spr(1'b1, 1'b0, 630, 0);
        step(p, s, 639, 0); chk("edge_nowrap", 1'b1, 16'd9);
        step(p, s, 5, 0);   chk("edge_wrapped", 1'b0, 16'hFFFF);

        // Zero sizes never hit
        step(mk_pat(5, 0, 16, 16, 16), mk_spr(1'b1, 1'b0, 0, 0), 0, 0); chk("zero_srcw", 1'b0, 16'hFFFF);
        step(mk_pat(5, 16, 16, 16, 0), mk_spr(1'b1, 1'b0, 0, 0), 0, 0); chk("zero_scrh", 1'b0, 16'hFFFF);

        // Mid-cycle reset while a hit is held
        p = mk_pat(256, 16, 16, 16, 16);
        s = mk_spr(1'b1, 1'b0, 100, 50);
        step(p, s, 101, 51); chk("pre_reset_hit", 1'b1, 16'd273);
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset", 1'b0, 16'hFFFF);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_hit", 1'b1, 16'd273);

        // Randomized placements around the sprite box
        for (int i = 0; i < 400; i++) begin
            p = mk_pat($urandom_range(0, 65535), $urandom_range(0, 40), $urandom_range(0, 40),
                       $urandom_range(0, 50), $urandom_range(0, 50));
            x = $urandom_range(0, 1023);
            y = $urandom_range(0, 1023);
            s = mk_spr(($urandom_range(0, 7) != 0), $urandom_range(0, 1), x, y);
            s[9:0] = $urandom_range(0, 1023);
            h = 10'(x + $urandom_range(0, 60) - 5);
            v = 10'(y + $urandom_range(0, 60) - 5);
            model(p, s, h, v, ev, ea);
            step(p, s, h, v);
            chk("random", ev, ea);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sprite_addr_calc.md
# sprite_addr_calc

Per-pixel sprite address generator for the Mario VGA sprite path, instantiated as `addr_cal`, once per sprite buffer inside each sprite display block. For the current beam position it decides whether the sprite covers the pixel. It also computes the pixel index into the 2-bit-per-pixel sprite ROM. The display block consumes the registered address and valid flag to pick a palette colour.

## Interface
- No parameters; field layouts come from the shared package.
- `clk` in 1: pixel clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low; clears outputs.
- `pattern_info` in 80: `[79:64]` ROM base (pixel index), `[63:48]` source width, `[47:32]` source height, `[31:16]` screen width, `[15:0]` screen height.
- `sprite_info` in 32: `[31]` visible, `[30]` flip-X, `[29:20]` X, `[19:10]` Y, `[9:0]` reserved.
- `hcount` in 10: current pixel column.
- `vcount` in 10: current pixel row.
- `addr_output` out 16: ROM pixel index; 16'hFFFF when not valid.
- `valid` out 1: sprite pixel present at the sampled position.

## Operation
- Screen box is columns [X, X+screen_w) and rows [Y, Y+screen_h).
- The box end is computed in 17 bits, so there is no wrap; boxes extend past 639/479 harmlessly.
- dx = hcount−X and dy = vcount−Y, computed only when inside the box.
- Hit requires all of: visible=1, hcount≥X, hcount<X+screen_w, vcount≥Y, vcount<Y+screen_h, dx<src_w, dy<src_h.
- Screen pixels beyond the source size are transparent. There is no scaling.
- Column: col = flip ? (src_w−1−dx) : dx.
- Address: addr = base + dy·src_w + col, as a 16-bit unsigned multiply-add truncated to 16 bits. Out-of-ROM checking is the consumer's job.
- On a hit: valid=1 and addr_output=addr.
- Otherwise: valid=0 and addr_output=16'hFFFF.
- A zero source or screen width/height never produces a hit.
- `sprite_info[9:0]` is ignored.

## Timing
- Single register stage: outputs reflect the inputs sampled at the previous rising edge, so latency is 1 clock.
- Inputs may change every cycle. There is no handshake and no stall.
- Reset asserted, even mid-frame: valid=0 and addr_output=16'hFFFF immediately.
- The first post-reset result appears on the first edge after deassertion.
- A simultaneous change of `sprite_info` and the beam position uses the new values together on the next edge.
- There are no partial updates.

## Configuration
- `ADDR_CAL_FLIP_EN` defined: `sprite_info[30]` mirrors the sprite horizontally, per Operation.
- `ADDR_CAL_FLIP_EN` undefined: bit 30 is ignored, col=dx always, and the subtractor is removed.

## Structure
- Package `sprite_pkg` holds:
  - packed struct `pattern_info_t` (base, src_w, src_h, scr_w, scr_h, each 16 bits);
  - packed struct `sprite_info_t` (visible, flip, x, y, reserved);
  - `INVALID_ADDR` = 16'hFFFF.
- Sub-module `sprite_hit` is purely combinational: box and source-bound compares producing hit, dx and dy.
- The top module adds flip, the multiply-add and the output register.

## Test plan
- Pattern {256,16,16,16,16}; sprite visible, X=100, Y=50, no flip; beam (100,50) → one clock later valid=1, addr=256. Beam (115,65) → addr=511.
- Same sprite, beam (116,50) and (99,50) → valid=0, addr=16'hFFFF. Visible=0 at (100,50) → valid=0.
- Pattern {1792,16,32,16,32}; X=0, Y=0; beam (3,20) → addr=1792+20·16+3=2115. Flip=1 → addr=2124 (col 12); with `ADDR_CAL_FLIP_EN` undefined it stays 2115.
- Pattern {0,16,16,32,32}; X=10, Y=10; beam (30,12) (dx=20 ≥ src_w) → valid=0. Beam (25,12) → addr=47.
- X=630, screen_w=16; beam (639,0) with Y=0 → valid=1 and no wrap. Beam (5,0) → valid=0.
- Hold a hit, assert reset mid-cycle → valid=0 and addr=16'hFFFF without waiting for a clock edge. Release → a correct result one clock later.
